barrel_shift_ctrl: RTL and testbench
====================================

// Module: barrel_shift_ctrl
// PURPOSE
//  Sequencer and arbiter for the shared 8-bit barrel shifter, which is built from 8:1 mux slices.
//  Two requesters (A, B) submit shift commands over valid/ready. The block grants them round-robin.
//  Amounts above 7 are split into passes of at most 7, because the shifter takes a 3-bit select.
//  The result is returned on one valid/ready output, tagged with the requester id.
// PARAMETERS
//  AMT_W  5  width of the requested shift amount (0..2^AMT_W-1); must be >= 3
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  a_valid      in   1      requester A command valid
//  a_ready      out  1      requester A command accepted when a_valid && a_ready
//  a_data       in   8      A operand
//  a_amt        in   AMT_W  A shift amount
//  a_rot        in   1      A mode: 1 = rotate left, 0 = logical left (zero fill)
//  b_valid/b_ready/b_data/b_amt/b_rot   same as the A ports, for requester B
//  sh_din       out  8      operand to the shifter (registered working value)
//  sh_amt       out  3      select/amount to the shifter for the current pass
//  sh_rot       out  1      mode to the shifter
//  sh_dout      in   8      combinational shifter result (same cycle)
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts when out_valid && out_ready
//  out_data     out  8      final shifted value
//  out_id       out  1      0 = requester A, 1 = requester B
//  busy         out  1      high in SHIFT or DONE
// BEHAVIOUR
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//    - IDLE goes straight to DONE when the accepted amt == 0.
//  Reset values:
//    - state IDLE, all outputs 0.
//    - RR pointer = "B last", so A wins the first tie.
//  Arbitration (IDLE only):
//    - a_ready/b_ready are combinational and asserted only in IDLE, for the single granted requester.
//    - Only one valid: that requester is granted.
//    - Both valid: the one not granted last is granted.
//    - The pointer updates on acceptance only.
//  On acceptance:
//    - Latch data into the working register, amt into remaining, rot, and id.
//  SHIFT, each cycle:
//    - pass = min(remaining, 7); sh_amt = pass; sh_din = working.
//    - Register working <= sh_dout and remaining <= remaining - pass.
//    - If remaining - pass == 0, go to DONE.
//  Outside SHIFT, sh_amt = 0 and sh_din = working.
//  Latency:
//    - out_valid rises ceil(amt/7)+1 cycles after the acceptance cycle.
//    - Examples: amt 0 -> 1 cycle, amt 7 -> 2, amt 10 -> 3, amt 31 -> 6.
//  DONE:
//    - out_valid = 1.
//    - out_data and out_id are held stable until out_ready.
//    - The handshake edge returns to IDLE with out_valid = 0.
//    - A new command can be accepted no earlier than the cycle after that edge.
//  Arithmetic rules:
//    - Rotates are cumulative, so the result is rotl(data, amt mod 8).
//    - Logical shifts with amt >= 8 yield 0x00. All passes are still executed.
//  Command inputs are ignored while busy; both readys are low.
//  Reset asserted mid-operation: the in-flight command is dropped, no out_valid is produced, and the FSM returns to IDLE.
// CONFIGURATION
//  BSC_STATS_EN defined:
//    - Adds output ops_cnt[15:0], reset 0.
//    - It increments on every out_valid && out_ready and wraps 0xFFFF -> 0x0000.
//  BSC_STATS_EN undefined:
//    - The port and counter do not exist.
//    - All other behaviour is identical.
// TESTING
//  - A: data 0x81, amt 1, rot 1 -> out_data 0x03, out_id 0; out_valid 2 cycles after accept.
//  - B: data 0x0F, amt 10, rot 0 -> two SHIFT cycles with sh_amt 7 then 3; out_data 0x00, out_id 1.
//  - A and B both valid from reset with distinct commands -> A served first, then B, then A again (RR alternation).
//  - A: data 0x5A, amt 0 -> out_data 0x5A after 1 cycle; no SHIFT state; sh_amt stays 0.
//  - Hold out_ready = 0 for 5 cycles in DONE -> out_data/out_id stable, a_ready/b_ready low; release -> IDLE.
//  - Assert rst_n low during SHIFT of amt 31 -> all outputs 0 immediately; no result delivered after release.

Source files
------------

// File: rtl/barrel_shift_ctrl.sv
// -----------------------------------------------------------------------------
// barrel_shift_ctrl
//
// Sequencer and round-robin arbiter in front of a shared 8-bit barrel shifter.
// The shifter itself lives outside this block: it is a purely combinational
// 8:1-mux-per-bit structure with a 3-bit amount select, so a request for a
// larger amount is walked through it in passes of at most 7 positions, feeding
// each pass result back into the working register.
//
// Two requesters (A and B) present commands over valid/ready. When both are
// valid in IDLE, the one that was not granted last wins. The final value comes
// back on a single valid/ready output tagged with the requester id.
//
// Optional feature (compile-time macro BSC_STATS_EN):
//   defined   -> adds output ops_cnt[15:0], a wrapping count of delivered
//                results (out_valid && out_ready).
//   undefined -> no ops_cnt port or counter; everything else is identical.
//
// Parameters
//   AMT_W      width of the requested shift amount, must be >= 3 (default 5)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   a_valid    in   1      requester A command valid
//   a_ready    out  1      requester A command accepted when a_valid && a_ready
//   a_data     in   8      requester A operand
//   a_amt      in   AMT_W  requester A shift amount
//   a_rot      in   1      requester A mode: 1 = rotate left, 0 = logical left
//   b_*        same as a_*, for requester B
//   sh_din     out  8      operand to the shifter (working register)
//   sh_amt     out  3      amount for the current pass, 0 outside SHIFT
//   sh_rot     out  1      mode to the shifter
//   sh_dout    in   8      combinational shifter result
//   out_valid  out  1      result valid (held in DONE)
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   out_data   out  8      final shifted value
//   out_id     out  1      0 = requester A, 1 = requester B
//   busy       out  1      high while in SHIFT or DONE
//   ops_cnt    out  16     delivered-result count (BSC_STATS_EN only)
// -----------------------------------------------------------------------------
module barrel_shift_ctrl #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [7:0]       a_data,
    input  logic [AMT_W-1:0] a_amt,
    input  logic             a_rot,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [7:0]       b_data,
    input  logic [AMT_W-1:0] b_amt,
    input  logic             b_rot,

    output logic [7:0]       sh_din,
    output logic [2:0]       sh_amt,
    output logic             sh_rot,
    input  logic [7:0]       sh_dout,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_id,
    output logic             busy
`ifdef BSC_STATS_EN
    ,
    output logic [15:0]      ops_cnt
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Largest amount the 3-bit shifter select can express in one pass.
    localparam logic [AMT_W-1:0] MAX_PASS = AMT_W'(7);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [7:0]       working_q;    // operand / partial result between passes
    logic [AMT_W-1:0] remaining_q;  // positions still to be shifted
    logic             rot_q;
    logic             id_q;
    logic             last_b_q;     // 1 = B was granted most recently

    // -------------------------------------------------------------------------
    // Arbitration: only meaningful in IDLE. On a tie the requester that was
    // not served last wins; a lone requester always wins.
    // -------------------------------------------------------------------------
    logic in_idle;
    logic grant_a;
    logic grant_b;
    logic accept;

    assign in_idle = (state_q == ST_IDLE);
    assign grant_a = a_valid && (!b_valid || last_b_q);
    assign grant_b = b_valid && (!a_valid || !last_b_q);
    assign a_ready = in_idle && grant_a;
    assign b_ready = in_idle && grant_b;
    assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

    // -------------------------------------------------------------------------
    // Pass sizing: min(remaining, 7), kept 3 bits wide since that is all the
    // shifter select can take.
    // -------------------------------------------------------------------------
    logic [2:0]       pass_amt;
    logic [AMT_W-1:0] remaining_next;

    assign pass_amt       = (remaining_q > MAX_PASS) ? 3'd7 : remaining_q[2:0];
    assign remaining_next = remaining_q - AMT_W'(pass_amt);

    // -------------------------------------------------------------------------
    // Shifter interface and result outputs. The working register doubles as
    // the result holding register, so out_data is stable for as long as DONE
    // is held by back-pressure.
    // -------------------------------------------------------------------------
    assign sh_din    = working_q;
    assign sh_amt    = (state_q == ST_SHIFT) ? pass_amt : 3'd0;
    assign sh_rot    = rot_q;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = working_q;
    assign out_id    = id_q;
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no
        // latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // A zero amount needs no pass through the shifter.
                    if ((grant_a ? a_amt : b_amt) == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (remaining_next == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            working_q   <= 8'h00;
            remaining_q <= '0;
            rot_q       <= 1'b0;
            id_q        <= 1'b0;
            // Pretend B went last so A wins the first tie after reset.
            last_b_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        working_q   <= grant_a ? a_data : b_data;
                        remaining_q <= grant_a ? a_amt  : b_amt;
                        rot_q       <= grant_a ? a_rot  : b_rot;
                        id_q        <= grant_b;
                        last_b_q    <= grant_b;
                    end
                end
                ST_SHIFT: begin
                    // Feeding each pass back makes rotates cumulative and
                    // drives logical shifts of 8 or more to zero naturally.
                    working_q   <= sh_dout;
                    remaining_q <= remaining_next;
                end
                default: begin
                    // DONE holds the result; nothing else changes.
                end
            endcase
        end
    end

`ifdef BSC_STATS_EN
    // -------------------------------------------------------------------------
    // Delivered-result counter; wraps naturally at 16 bits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_cnt <= 16'h0000;
        end else if (out_valid && out_ready) begin
            ops_cnt <= ops_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_ctrl
//
// Self-checking bench for barrel_shift_ctrl. The shared shifter is modelled
// combinationally here; expected results, pass sequences and latencies come
// from a reference model written directly from the arithmetic rules.
// -----------------------------------------------------------------------------
module tb_barrel_shift_ctrl;

    localparam int AMT_W = 5;

    logic             clk;
    logic             rst_n;
    logic             a_valid, a_ready, a_rot;
    logic [7:0]       a_data;
    logic [AMT_W-1:0] a_amt;
    logic             b_valid, b_ready, b_rot;
    logic [7:0]       b_data;
    logic [AMT_W-1:0] b_amt;
    logic [7:0]       sh_din;
    logic [2:0]       sh_amt;
    logic             sh_rot;
    logic [7:0]       sh_dout;
    logic             out_valid, out_ready, out_id, busy;
    logic [7:0]       out_data;
`ifdef BSC_STATS_EN
    logic [15:0]      ops_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    barrel_shift_ctrl #(.AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_amt     (a_amt),
        .a_rot     (a_rot),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_amt     (b_amt),
        .b_rot     (b_rot),
        .sh_din    (sh_din),
        .sh_amt    (sh_amt),
        .sh_rot    (sh_rot),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
`ifdef BSC_STATS_EN
        ,
        .ops_cnt   (ops_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shifter model: one 3-bit pass, rotate or zero-fill.
    logic [15:0] sh_dbl;
    always_comb begin
        sh_dbl  = {sh_din, sh_din} << sh_amt;
        sh_dout = sh_rot ? sh_dbl[15:8] : (sh_din << sh_amt);
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic logic [7:0] ref_result(input logic [7:0] d, input int amt, input bit rot);
        int k;
        if (rot) begin
            k = amt % 8;
            return (d << k) | (d >> (8 - k));
        end
        if (amt >= 8) return 8'h00;
        return d << amt;
    endfunction

    function automatic int ref_latency(input int amt);
        return (amt + 6) / 7 + 1;
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input bit id, input logic [7:0] d, input int amt, input bit rot);
        if (!id) begin
            a_valid = 1'b1; a_data = d; a_amt = AMT_W'(amt); a_rot = rot;
        end else begin
            b_valid = 1'b1; b_data = d; b_amt = AMT_W'(amt); b_rot = rot;
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_data = 8'h00; a_amt = '0; a_rot = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_amt = '0; b_rot = 1'b0;
    endtask

    // Issue one command from a single requester, follow every pass and check
    // pass amounts, latency, result, tag and return to idle.
    task automatic run_cmd(input string tag, input bit id, input logic [7:0] d,
                           input int amt, input bit rot);
        logic [7:0] exp_data;
        int exp_lat, cyc, rem, p, exp_amt;
        int passes[$];
        exp_data = ref_result(d, amt, rot);
        exp_lat  = ref_latency(amt);
        rem = amt;
        while (rem > 0) begin
            p = (rem > 7) ? 7 : rem;
            passes.push_back(p);
            rem -= p;
        end
        out_ready = 1'b1;
        drive_cmd(id, d, amt, rot);
        #1;
        n_checks++;
        if ((id ? b_ready : a_ready) !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready: got %b, required 1", tag, id ? b_ready : a_ready);
        end
        tick();
        idle_inputs();
        cyc = 1;
        while (out_valid !== 1'b1 && cyc <= 40) begin
            exp_amt = (cyc - 1 < passes.size()) ? passes[cyc-1] : 0;
            n_checks++;
            if (sh_amt !== 3'(exp_amt)) begin
                n_fail++;
                $display("FAIL %s sh_amt pass %0d: got %0d, required %0d", tag, cyc, sh_amt, exp_amt);
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (cyc !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", tag, cyc, exp_lat);
        end
        n_checks++;
        if (out_data !== exp_data || out_id !== id) begin
            n_fail++;
            $display("FAIL %s result: got data %02h id %b, required data %02h id %b",
                     tag, out_data, out_id, exp_data, id);
        end
        n_checks++;
        if (sh_amt !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done state: got sh_amt %0d busy %b, required 0 1", tag, sh_amt, busy);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after handshake: got out_valid %b busy %b, required 0 0",
                     tag, out_valid, busy);
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        idle_inputs();
        repeat (2) tick();
        n_checks++;
        if ({a_ready, b_ready, sh_din, sh_amt, sh_rot, out_valid, out_data, out_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got rdy %b%b din %02h amt %0d rot %b ov %b od %02h id %b busy %b, required all 0",
                     a_ready, b_ready, sh_din, sh_amt, sh_rot, out_valid, out_data, out_id, busy);
        end
`ifdef BSC_STATS_EN
        n_checks++;
        if (ops_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset ops_cnt: got %04h, required 0000", ops_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_cmd("a_rot1",      1'b0, 8'h81, 1,  1'b1);
        run_cmd("b_lsl10",     1'b1, 8'h0F, 10, 1'b0);
        run_cmd("a_amt0",      1'b0, 8'h5A, 0,  1'b0);
        run_cmd("b_rot7",      1'b1, 8'h96, 7,  1'b1);
        run_cmd("a_lsl7",      1'b0, 8'hFF, 7,  1'b0);
        run_cmd("b_lsl8",      1'b1, 8'hFF, 8,  1'b0);
        run_cmd("a_rot14",     1'b0, 8'h3C, 14, 1'b1);
        run_cmd("b_rot31",     1'b1, 8'hA5, 31, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_cmd("random", 1'($urandom_range(0, 1)), 8'($urandom),
                    int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Both requesters stay valid from reset; grants must alternate A, B, A.
    task automatic test_round_robin();
        logic [7:0] got_data[$];
        bit         got_id[$];
        logic [7:0] cmd_d[2];
        int         cmd_amt[2];
        bit         cmd_rot[2];
        int         cyc;
        bit         exp_order[3];
        cmd_d[0] = 8'h11; cmd_amt[0] = 3; cmd_rot[0] = 1'b0;
        cmd_d[1] = 8'hC2; cmd_amt[1] = 9; cmd_rot[1] = 1'b1;
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0;
        test_reset();
        out_ready = 1'b1;
        drive_cmd(1'b0, cmd_d[0], cmd_amt[0], cmd_rot[0]);
        drive_cmd(1'b1, cmd_d[1], cmd_amt[1], cmd_rot[1]);
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rr first tie: got a_ready %b b_ready %b, required 1 0", a_ready, b_ready);
        end
        cyc = 0;
        while (got_id.size() < 3 && cyc < 100) begin
            if (out_valid === 1'b1) begin
                got_id.push_back(out_id);
                got_data.push_back(out_data);
            end
            if (got_id.size() < 3) tick();
            cyc++;
        end
        idle_inputs();
        tick();
        n_checks++;
        if (got_id.size() != 3) begin
            n_fail++;
            $display("FAIL rr result count: got %0d, required 3", got_id.size());
        end
        for (int i = 0; i < got_id.size(); i++) begin
            n_checks++;
            if (got_id[i] !== exp_order[i] ||
                got_data[i] !== ref_result(cmd_d[exp_order[i]], cmd_amt[exp_order[i]], cmd_rot[exp_order[i]])) begin
                n_fail++;
                $display("FAIL rr result %0d: got id %b data %02h, required id %b data %02h", i,
                         got_id[i], got_data[i], exp_order[i],
                         ref_result(cmd_d[exp_order[i]], cmd_amt[exp_order[i]], cmd_rot[exp_order[i]]));
            end
        end
    endtask

    // Back-pressure in DONE: result held, new commands refused.
    task automatic test_backpressure();
        logic [7:0] exp_data;
        int         cyc;
        exp_data  = ref_result(8'hC3, 5, 1'b1);
        out_ready = 1'b0;
        drive_cmd(1'b0, 8'hC3, 5, 1'b1);
        tick();
        idle_inputs();
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        drive_cmd(1'b0, 8'h01, 2, 1'b0);
        drive_cmd(1'b1, 8'h02, 3, 1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_data || out_id !== 1'b0 ||
                a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got ov %b data %02h id %b rdy %b%b, required 1 %02h 0 00",
                         i, out_valid, out_data, out_id, a_ready, b_ready, exp_data);
            end
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold release: got out_valid %b busy %b, required 0 0", out_valid, busy);
        end
    endtask

    // Reset during a long SHIFT drops the command entirely.
    task automatic test_reset_midop();
        bit seen;
        out_ready = 1'b1;
        drive_cmd(1'b1, 8'hA5, 31, 1'b1);
        tick();
        idle_inputs();
        tick();
        n_checks++;
        if (busy !== 1'b1 || sh_amt !== 3'd7) begin
            n_fail++;
            $display("FAIL midop in shift: got busy %b sh_amt %0d, required 1 7", busy, sh_amt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, b_ready, sh_din, sh_amt, sh_rot, out_valid, out_data, out_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL midop reset outputs: got din %02h amt %0d rot %b ov %b od %02h id %b busy %b, required all 0",
                     sh_din, sh_amt, sh_rot, out_valid, out_data, out_id, busy);
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop dropped: got activity after reset %b, required 0", seen);
        end
        run_cmd("post_reset", 1'b0, 8'h81, 1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
